// File: rtl/keypoint_extrema_detect.sv
// keypoint_extrema_detect
//   Streaming 3x3x3 scale-space extremum detector. Each in_valid beat carries
//   one DoG column (3 scales x 3 rows). A 3-column window is assembled. The
//   centre sample (scale 2, row 2, middle column) is compared against its 26
//   neighbours. Strict extrema above the contrast threshold are tagged with
//   (x, y) and queued in a small FIFO toward the descriptor stage.
//
//   Pipeline: S0 window/coords, S1 registered comparisons, S2 reduce + push.
//
//   Configuration macro: KP_MIN_DETECT_EN
//     defined   -> minima are also reported; kp_max tells max (1) from min (0)
//     undefined -> only maxima are reported; kp_max is constant 1
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid              DoG column qualifier (no backpressure upstream)
//   DoG_<s>_<r>           17-bit signed DoG, scale s (1..3), row r (y-1..y+1)
//   kp_valid / kp_ready   keypoint FIFO head handshake
//   kp_x, kp_y            centre coordinates
//   kp_max                1 = maximum, 0 = minimum
//   kp_dog                centre DoG value
//   overflow              sticky, set when a keypoint is dropped on a full FIFO
//   drop_cnt              saturating count of dropped keypoints
module keypoint_extrema_detect #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int CONTRAST_TH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [16:0]    DoG_1_1,
  input  logic [16:0]    DoG_1_2,
  input  logic [16:0]    DoG_1_3,
  input  logic [16:0]    DoG_2_1,
  input  logic [16:0]    DoG_2_2,
  input  logic [16:0]    DoG_2_3,
  input  logic [16:0]    DoG_3_1,
  input  logic [16:0]    DoG_3_2,
  input  logic [16:0]    DoG_3_3,
  output logic           kp_valid,
  input  logic           kp_ready,
  output logic [X_W-1:0] kp_x,
  output logic [Y_W-1:0] kp_y,
  output logic           kp_max,
  output logic [16:0]    kp_dog,
  output logic           overflow,
  output logic [15:0]    drop_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  // Column entry index = (scale-1)*3 + (row-1); entry 4 is the centre row of scale 2.
  logic signed [16:0] newCol [9];
  assign newCol[0] = DoG_1_1;
  assign newCol[1] = DoG_1_2;
  assign newCol[2] = DoG_1_3;
  assign newCol[3] = DoG_2_1;
  assign newCol[4] = DoG_2_2;
  assign newCol[5] = DoG_2_3;
  assign newCol[6] = DoG_3_1;
  assign newCol[7] = DoG_3_2;
  assign newCol[8] = DoG_3_3;

  // ---------------- S0: window shift register and coordinates ----------------
  // win[0] is the newest column; win[1] holds the centre column.
  logic signed [16:0] win [3][9];
  logic [X_W-1:0]     colCnt;
  logic [Y_W-1:0]     rowCnt;
  logic               s0Valid;
  logic [X_W-1:0]     s0X;
  logic [Y_W-1:0]     s0Y;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int e = 0; e < 9; e++) begin
        win[0][e] <= newCol[e];
        win[1][e] <= win[0][e];
        win[2][e] <= win[1][e];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      colCnt  <= '0;
      rowCnt  <= Y_W'(1);
      s0Valid <= 1'b0;
      s0X     <= '0;
      s0Y     <= '0;
    end else begin
      // The first two beats of a row still carry columns of the previous row.
      s0Valid <= in_valid && (colCnt >= X_W'(2));
      if (in_valid) begin
        s0X <= colCnt - X_W'(1);
        s0Y <= rowCnt;
        if (colCnt == X_W'(IMG_WIDTH - 1)) begin
          colCnt <= '0;
          rowCnt <= (rowCnt == Y_W'(IMG_HEIGHT - 2)) ? Y_W'(1) : rowCnt + Y_W'(1);
        end else begin
          colCnt <= colCnt + X_W'(1);
        end
      end
    end
  end

  // ---------------- S1: 26 neighbour comparisons ----------------
  logic signed [16:0] centre;
  logic [26:0]        gtComb;
  assign centre = win[1][4];

  // Cube index gi = column*9 + entry; gi == 13 is the centre itself.
  generate
    for (genvar gi = 0; gi < 27; gi++) begin : g_gt
      if (gi == 13) begin : g_self
        assign gtComb[gi] = 1'b1;
      end else begin : g_nb
        assign gtComb[gi] = centre > win[gi / 9][gi % 9];
      end
    end
  endgenerate

`ifdef KP_MIN_DETECT_EN
  logic [26:0] ltComb;
  logic [26:0] s1Lt;
  generate
    for (genvar gi = 0; gi < 27; gi++) begin : g_lt
      if (gi == 13) begin : g_self
        assign ltComb[gi] = 1'b1;
      end else begin : g_nb
        assign ltComb[gi] = centre < win[gi / 9][gi % 9];
      end
    end
  endgenerate
`endif

  logic               s1Valid;
  logic [26:0]        s1Gt;
  logic signed [16:0] s1Dog;
  logic [X_W-1:0]     s1X;
  logic [Y_W-1:0]     s1Y;

  always_ff @(posedge clk) begin
    if (rst) s1Valid <= 1'b0;
    else     s1Valid <= s0Valid;
  end

  always_ff @(posedge clk) begin
    s1Gt  <= gtComb;
    s1Dog <= centre;
    s1X   <= s0X;
    s1Y   <= s0Y;
`ifdef KP_MIN_DETECT_EN
    s1Lt  <= ltComb;
`endif
  end

  // ---------------- S2: reduce, contrast threshold ----------------
  logic        isMaxS2;
  logic        isMinS2;
  logic [17:0] dogExt;
  logic [17:0] dogAbs;
  logic        s2Pass;

  assign isMaxS2 = &s1Gt;
`ifdef KP_MIN_DETECT_EN
  assign isMinS2 = &s1Lt;
`else
  assign isMinS2 = 1'b0;
`endif
  // 18-bit magnitude so that -65536 maps to +65536.
  assign dogExt = {s1Dog[16], s1Dog};
  assign dogAbs = s1Dog[16] ? (18'd0 - dogExt) : dogExt;
  assign s2Pass = s1Valid && (isMaxS2 || isMinS2) && (dogAbs > 18'(CONTRAST_TH));

  // ---------------- Keypoint FIFO with registered head ----------------
  logic [X_W-1:0] memX   [FIFO_DEPTH];
  logic [Y_W-1:0] memY   [FIFO_DEPTH];
  logic [16:0]    memDog [FIFO_DEPTH];
  logic [PW-1:0]  rdPtr, wrPtr, nextRd;
  logic [CW-1:0]  count, countNext;
  logic           kpValidReg, pop, full, pushOk, dropEvt;
  logic [X_W-1:0] headX;
  logic [Y_W-1:0] headY;
  logic [16:0]    headDog;
  logic           overflowReg;
  logic [15:0]    dropCnt;

  assign pop     = kpValidReg && kp_ready;
  assign full    = (count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the push needs.
  assign pushOk  = s2Pass && (!full || pop);
  assign dropEvt = s2Pass && full && !pop;
  assign nextRd  = rdPtr + PW'(1);

  always_comb begin
    countNext = count;
    if (pushOk && !pop)      countNext = count + CW'(1);
    else if (!pushOk && pop) countNext = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (pushOk) begin
      memX[wrPtr]   <= s1X;
      memY[wrPtr]   <= s1Y;
      memDog[wrPtr] <= s1Dog;
    end
  end

`ifdef KP_MIN_DETECT_EN
  logic memMax [FIFO_DEPTH];
  logic headMax;
  always_ff @(posedge clk) begin
    if (pushOk) memMax[wrPtr] <= isMaxS2;
  end
  always_ff @(posedge clk) begin
    if (rst) headMax <= 1'b0;
    else if (pop && count > CW'(1)) headMax <= memMax[nextRd];
    else if (pushOk && (count == '0 || pop)) headMax <= isMaxS2;
  end
  assign kp_max = headMax;
`else
  assign kp_max = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      kpValidReg  <= 1'b0;
      headX       <= '0;
      headY       <= '0;
      headDog     <= '0;
      overflowReg <= 1'b0;
      dropCnt     <= '0;
    end else begin
      count      <= countNext;
      kpValidReg <= (countNext != '0);
      if (pushOk) wrPtr <= wrPtr + PW'(1);
      if (pop)    rdPtr <= nextRd;
      // Head follows the next stored entry, or the incoming push when the
      // FIFO is (or is about to become) empty.
      if (pop && count > CW'(1)) begin
        headX   <= memX[nextRd];
        headY   <= memY[nextRd];
        headDog <= memDog[nextRd];
      end else if (pushOk && (count == '0 || pop)) begin
        headX   <= s1X;
        headY   <= s1Y;
        headDog <= s1Dog;
      end
      if (dropEvt) begin
        overflowReg <= 1'b1;
        if (dropCnt != 16'hFFFF) dropCnt <= dropCnt + 16'd1;
      end
    end
  end

  assign kp_valid = kpValidReg;
  assign kp_x     = headX;
  assign kp_y     = headY;
  assign kp_dog   = headDog;
  assign overflow = overflowReg;
  assign drop_cnt = dropCnt;

endmodule

// File: tb/tb_keypoint_extrema_detect.sv
module tb_keypoint_extrema_detect;
  localparam int W = 16;
  localparam int H = 6;
  localparam int TH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        kp_ready = 1'b1;
  logic [16:0] dIn [9];
  logic        kp_valid, kp_max, overflow;
  logic [10:0] kp_x;
  logic [9:0]  kp_y;
  logic [16:0] kp_dog;
  logic [15:0] drop_cnt;

  keypoint_extrema_detect #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .X_W(11), .Y_W(10),
    .CONTRAST_TH(TH), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .DoG_1_1(dIn[0]), .DoG_1_2(dIn[1]), .DoG_1_3(dIn[2]),
    .DoG_2_1(dIn[3]), .DoG_2_2(dIn[4]), .DoG_2_3(dIn[5]),
    .DoG_3_1(dIn[6]), .DoG_3_2(dIn[7]), .DoG_3_3(dIn[8]),
    .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y),
    .kp_max(kp_max), .kp_dog(kp_dog), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int mx; int dog;} kp_t;
  kp_t expQ[$];
  kp_t obsQ[$];
  int  total = 0;
  int  bad = 0;
  int  mCol, mRow;
  int  hist [3][9];
  int  cv [9];

`ifdef KP_MIN_DETECT_EN
  localparam int MIN_EN = 1;
`else
  localparam int MIN_EN = 0;
`endif

  // Record every accepted keypoint (head sampled mid-cycle, before the popping edge).
  always @(negedge clk) begin
    kp_t o;
    if (!rst && kp_valid && kp_ready) begin
      o.x = int'(kp_x); o.y = int'(kp_y); o.mx = int'(kp_max); o.dog = int'($signed(kp_dog));
      obsQ.push_back(o);
      $display("pop x=%0d y=%0d max=%0d dog=%0d", o.x, o.y, o.mx, o.dog);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: image position, the last three columns, and the
  // extremum rules evaluated over the full 3x3x3 cube.
  task automatic model_beat();
    int c;
    bit isMax, isMin;
    kp_t k;
    for (int e = 0; e < 9; e++) begin
      hist[2][e] = hist[1][e];
      hist[1][e] = hist[0][e];
      hist[0][e] = cv[e];
    end
    if (mCol >= 2) begin
      c = hist[1][4];
      isMax = 1; isMin = 1;
      for (int col = 0; col < 3; col++)
        for (int e = 0; e < 9; e++)
          if (!(col == 1 && e == 4)) begin
            if (hist[col][e] >= c) isMax = 0;
            if (hist[col][e] <= c) isMin = 0;
          end
      if (MIN_EN == 0) isMin = 0;
      if ((isMax || isMin) && ((c < 0) ? -c : c) > TH) begin
        k.x = mCol - 1; k.y = mRow; k.mx = isMax ? 1 : 0; k.dog = c;
        expQ.push_back(k);
      end
    end
    mCol++;
    if (mCol == W) begin
      mCol = 0;
      mRow = (mRow == H - 2) ? 1 : mRow + 1;
    end
  endtask

  task automatic send();
    for (int e = 0; e < 9; e++) dIn[e] = 17'(cv[e]);
    in_valid = 1'b1;
    model_beat();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic zero_cv();
    for (int e = 0; e < 9; e++) cv[e] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    mCol = 0; mRow = 1;
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_reset();
    do_reset();
    kp_ready = 1'b1;
    // Passing window in flight when reset hits: it must be discarded.
    for (int col = 0; col < 3; col++) begin
      zero_cv();
      if (col == 1) cv[4] = 50;
      send();
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      for (int e = 0; e < 9; e++) dIn[e] = 17'($urandom);
      tick();
    end
    in_valid = 1'b0;
    total++; if (kp_valid !== 1'b0) begin bad++; $display("FAIL reset_kp_valid got %0b want 0", kp_valid); end
    total++; if (kp_x !== 11'd0) begin bad++; $display("FAIL reset_kp_x got %0d want 0", kp_x); end
    total++; if (kp_y !== 10'd0) begin bad++; $display("FAIL reset_kp_y got %0d want 0", kp_y); end
    total++; if (kp_max !== 1'(MIN_EN == 0)) begin bad++; $display("FAIL reset_kp_max got %0b want %0d", kp_max, MIN_EN == 0); end
    total++; if (kp_dog !== 17'd0) begin bad++; $display("FAIL reset_kp_dog got %0d want 0", kp_dog); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    rst = 1'b0;
    mCol = 0; mRow = 1; expQ.delete(); obsQ.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (kp_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle cycle %0d kp_valid got %0b want 0", i, kp_valid); end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_max();
    do_reset();
    kp_ready = 1'b1;
    for (int col = 0; col < 6; col++) begin
      zero_cv();
      if (col == 4) cv[4] = 100;
      send();
    end
    total++; if (kp_valid !== 1'b0) begin bad++; $display("FAIL latency_t1 kp_valid got %0b want 0", kp_valid); end
    tick();
    total++; if (kp_valid !== 1'b0) begin bad++; $display("FAIL latency_t2 kp_valid got %0b want 0", kp_valid); end
    tick();
    total++; if (kp_valid !== 1'b1) begin bad++; $display("FAIL latency_t3 kp_valid got %0b want 1", kp_valid); end
    total++; if (kp_x !== 11'd4 || kp_y !== 10'd1 || kp_max !== 1'b1 || kp_dog !== 17'd100) begin
      bad++; $display("FAIL single_max_head got x=%0d y=%0d max=%0b dog=%0d want x=4 y=1 max=1 dog=100", kp_x, kp_y, kp_max, kp_dog);
    end
    for (int col = 6; col < 10; col++) begin zero_cv(); send(); end
    repeat (5) tick();
    total++; if (obsQ.size() != 1) begin bad++; $display("FAIL single_max_count got %0d want 1", obsQ.size()); end
    $display("test_single_max done");
  endtask

  task automatic test_tie_threshold();
    int cVal [3] = '{100, 8, 9};
    int wantN [3] = '{0, 0, 1};
    int nIdx;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      kp_ready = 1'b1;
      nIdx = $urandom_range(0, 25);
      if (nIdx >= 13) nIdx++;
      for (int col = 0; col < 6; col++) begin
        zero_cv();
        if (col == 4) cv[4] = cVal[t];
        if (t == 0 && col == 3 + nIdx / 9) cv[nIdx % 9] = 100;
        send();
      end
      repeat (6) tick();
      total++; if (obsQ.size() != wantN[t]) begin
        bad++; $display("FAIL tie_thresh case %0d (C=%0d tie_pos=%0d) count got %0d want %0d", t, cVal[t], nIdx, obsQ.size(), wantN[t]);
      end else if (wantN[t] == 1) begin
        total++; if (obsQ[0].dog != 9 || obsQ[0].x != 4) begin bad++; $display("FAIL tie_thresh_c9 got x=%0d dog=%0d want x=4 dog=9", obsQ[0].x, obsQ[0].dog); end
      end
    end
    $display("test_tie_threshold done");
  endtask

  task automatic test_minimum();
    do_reset();
    kp_ready = 1'b1;
    for (int col = 0; col < 6; col++) begin
      zero_cv();
      if (col == 4) cv[4] = -65536;
      send();
    end
    repeat (6) tick();
    total++; if (obsQ.size() != MIN_EN) begin bad++; $display("FAIL minimum_count got %0d want %0d", obsQ.size(), MIN_EN); end
    else if (MIN_EN == 1) begin
      total++; if (obsQ[0].mx != 0 || obsQ[0].dog != -65536 || obsQ[0].x != 4 || obsQ[0].y != 1) begin
        bad++; $display("FAIL minimum_head got x=%0d y=%0d max=%0d dog=%0d want x=4 y=1 max=0 dog=-65536", obsQ[0].x, obsQ[0].y, obsQ[0].mx, obsQ[0].dog);
      end
    end
    $display("test_minimum done");
  endtask

  task automatic test_overflow();
    do_reset();
    kp_ready = 1'b0;
    // Maxima centred on columns 3,5,...,13 with values 100..105.
    for (int col = 0; col < W; col++) begin
      zero_cv();
      if (col >= 3 && col <= 13 && (col % 2) == 1) cv[4] = 100 + (col - 3) / 2;
      send();
    end
    repeat (5) tick();
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    total++; if (kp_valid !== 1'b1 || kp_x !== 11'd3 || kp_dog !== 17'd100) begin
      bad++; $display("FAIL ovf_head got valid=%0b x=%0d dog=%0d want valid=1 x=3 dog=100", kp_valid, kp_x, kp_dog);
    end
    repeat (3) tick();
    total++; if (kp_x !== 11'd3 || kp_y !== 10'd1 || kp_dog !== 17'd100) begin
      bad++; $display("FAIL ovf_head_hold got x=%0d y=%0d dog=%0d want x=3 y=1 dog=100", kp_x, kp_y, kp_dog);
    end
    kp_ready = 1'b1;
    repeat (8) tick();
    total++; if (obsQ.size() != 4) begin bad++; $display("FAIL ovf_drain_count got %0d want 4", obsQ.size()); end
    for (int i = 0; i < 4 && i < obsQ.size(); i++) begin
      total++; if (obsQ[i].x != 3 + 2 * i || obsQ[i].y != 1 || obsQ[i].mx != 1 || obsQ[i].dog != 100 + i) begin
        bad++; $display("FAIL ovf_order idx %0d got x=%0d y=%0d max=%0d dog=%0d want x=%0d y=1 max=1 dog=%0d",
                        i, obsQ[i].x, obsQ[i].y, obsQ[i].mx, obsQ[i].dog, 3 + 2 * i, 100 + i);
      end
    end
    total++; if (kp_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty kp_valid got %0b want 0", kp_valid); end
    $display("test_overflow done");
  endtask

  task automatic test_wrap();
    do_reset();
    kp_ready = 1'b1;
    // Column W-1 carries a tall centre that only a stale window could report;
    // column 1 carries a genuine maximum in every row.
    for (int b = 0; b < W * (H - 2) + 3; b++) begin
      zero_cv();
      if (b % W == W - 1) cv[4] = 3000;
      if (b % W == 1) cv[4] = 500;
      send();
    end
    repeat (6) tick();
    total++; if (obsQ.size() != H - 1 || expQ.size() != H - 1) begin
      bad++; $display("FAIL wrap_count got %0d want %0d", obsQ.size(), H - 1);
    end
    for (int i = 0; i < obsQ.size() && i < H - 1; i++) begin
      total++; if (obsQ[i].x != 1 || obsQ[i].y != (i % (H - 2)) + 1 || obsQ[i].dog != 500) begin
        bad++; $display("FAIL wrap_kp idx %0d got x=%0d y=%0d dog=%0d want x=1 y=%0d dog=500", i, obsQ[i].x, obsQ[i].y, obsQ[i].dog, (i % (H - 2)) + 1);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    int mode;
    do_reset();
    kp_ready = 1'b1;
    for (int b = 0; b < 400; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
      end else begin
        mode = $urandom_range(0, 2);
        for (int e = 0; e < 9; e++)
          cv[e] = (mode == 1) ? int'($urandom_range(0, 131071)) - 65536 : int'($urandom_range(0, 40)) - 20;
        if (mode == 2) cv[4] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 300)) : -int'($urandom_range(10, 300));
        send();
      end
    end
    repeat (6) tick();
    total++; if (obsQ.size() != expQ.size()) begin bad++; $display("FAIL random_count got %0d want %0d", obsQ.size(), expQ.size()); end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      total++; if (obsQ[i].x != expQ[i].x || obsQ[i].y != expQ[i].y || obsQ[i].mx != expQ[i].mx || obsQ[i].dog != expQ[i].dog) begin
        bad++; $display("FAIL random_kp idx %0d got x=%0d y=%0d max=%0d dog=%0d want x=%0d y=%0d max=%0d dog=%0d", i,
                        obsQ[i].x, obsQ[i].y, obsQ[i].mx, obsQ[i].dog, expQ[i].x, expQ[i].y, expQ[i].mx, expQ[i].dog);
      end
    end
    total++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin bad++; $display("FAIL random_no_drop got drop=%0d ovf=%0b want 0 0", drop_cnt, overflow); end
    $display("test_random done: %0d keypoints", obsQ.size());
  endtask

  initial begin
    for (int e = 0; e < 9; e++) dIn[e] = '0;
    mCol = 0; mRow = 1;
    for (int c = 0; c < 3; c++) for (int e = 0; e < 9; e++) hist[c][e] = 0;
    test_reset();
    test_single_max();
    test_tie_threshold();
    test_minimum();
    test_overflow();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
